// File: rtl/sr_drive_ctrl_if.sv
// rtl/sr_drive_ctrl_if.sv - command/drive bundle between requester, SR flop and sr_drive_ctrl
// Purpose: groups the request handshake, the flop feedback and the S/R drive/status
//   outputs so the controller and its user share one connection.
// Signals:
//   req_valid, req_op  : command from requester (op 1 = set, 0 = clear)
//   req_ready          : controller can accept (idle)
//   q_fb               : Q of the downstream SR flop
//   s, r               : registered drives into the SR flop
//   busy, done, err    : status; done/err are one-cycle pulses
//   err_cnt            : saturating count of err pulses
interface sr_drive_ctrl_if;
  logic       req_valid;
  logic       req_op;
  logic       req_ready;
  logic       q_fb;
  logic       s;
  logic       r;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] err_cnt;

  modport master (
    output req_valid, req_op, q_fb,
    input  req_ready, s, r, busy, done, err, err_cnt
  );

  modport slave (
    input  req_valid, req_op, q_fb,
    output req_ready, s, r, busy, done, err, err_cnt
  );
endinterface

// File: rtl/sr_drive_ctrl.sv
// rtl/sr_drive_ctrl.sv - pulse-width controlled S/R driver with Q check and error count
// Purpose: accepts set/clear commands, pulses S or R for PULSE_CYCLES, checks the
//   flop Q for up to CHECK_TIMEOUT cycles, reports done/err, then idles GAP_CYCLES.
// Ports:
//   i_clk   : clock, all logic on posedge
//   i_rst_n : asynchronous active-low reset
//   bus     : sr_drive_ctrl_if.slave (request in, q_fb in, drives/status out)
module sr_drive_ctrl #(
  parameter int PULSE_CYCLES  = 2,
  parameter int CHECK_TIMEOUT = 4,
  parameter int GAP_CYCLES    = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  sr_drive_ctrl_if.slave bus
);

  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam int TW = $clog2(CHECK_TIMEOUT + 1);
  // a zero-length gap still needs a legal (unused) counter width
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  logic [1:0]    r_state;
  logic          r_op;
  logic          r_s;
  logic          r_r;
  logic          r_done;
  logic          r_err;
  logic [7:0]    r_err_cnt;
  logic [PW-1:0] r_pulse_cnt;
  logic [TW-1:0] r_chk_cnt;
  logic [GW-1:0] r_gap_cnt;
  logic [1:0]    w_after_check;

  // with no gap the result pulse lands in the first idle cycle
  assign w_after_check = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= 1'b0;
      r_s         <= 1'b0;
      r_r         <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_cnt   <= 8'd0;
      r_pulse_cnt <= '0;
      r_chk_cnt   <= '0;
      r_gap_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_op <= bus.req_op;
            if (bus.req_op == bus.q_fb) begin
              // flop already holds the commanded value: complete without a pulse
              r_done <= 1'b1;
            end else begin
              r_state     <= ST_DRIVE;
              r_s         <= bus.req_op;
              r_r         <= ~bus.req_op;
              r_pulse_cnt <= '0;
            end
          end
        end
        ST_DRIVE: begin
          if (r_pulse_cnt == PW'(PULSE_CYCLES - 1)) begin
            // both drives drop together, so S and R can never overlap
            r_s       <= 1'b0;
            r_r       <= 1'b0;
            r_chk_cnt <= '0;
            r_state   <= ST_CHECK;
          end else begin
            r_pulse_cnt <= r_pulse_cnt + PW'(1);
          end
        end
        ST_CHECK: begin
          if (bus.q_fb == r_op) begin
            r_done    <= 1'b1;
            r_gap_cnt <= '0;
            r_state   <= w_after_check;
          end else if (r_chk_cnt == TW'(CHECK_TIMEOUT - 1)) begin
            r_err <= 1'b1;
            if (r_err_cnt != 8'hFF) begin
              r_err_cnt <= r_err_cnt + 8'd1;
            end
            r_gap_cnt <= '0;
            r_state   <= w_after_check;
          end else begin
            r_chk_cnt <= r_chk_cnt + TW'(1);
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == GW'(GAP_CYCLES - 1)) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.s         = r_s;
  assign bus.r         = r_r;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.err_cnt   = r_err_cnt;

endmodule
